// File: rtl/ps2_dev_tx_if.sv
// rtl/ps2_dev_tx_if.sv - host-side write/status bus for the PS/2 device transmitter
interface ps2_dev_tx_if #(
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0]   wr;
  logic [8*CHANNELS-1:0] din;
  logic [CHANNELS-1:0]   ovf_clr;
  logic [CHANNELS-1:0]   full;
  logic [CHANNELS-1:0]   empty;
  logic [CHANNELS-1:0]   overflow;
  logic [CHANNELS-1:0]   busy;

  modport master (output wr, din, ovf_clr, input full, empty, overflow, busy);
  modport slave  (input wr, din, ovf_clr, output full, empty, overflow, busy);
endinterface

// File: rtl/ps2_dev_tx.sv
// rtl/ps2_dev_tx.sv - N-channel PS/2 device transmitter, per-channel FIFO and frame serialiser
// Define PS2_HOST_INHIBIT_EN to enable host-inhibit abort/retry on host_clk_in.
module ps2_dev_tx #(
  parameter int CHANNELS  = 2,
  parameter int FIFO_BITS = 3,
  parameter int GAP       = 1
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                ps2_clk,
  input  logic [CHANNELS-1:0] host_clk_in,
  ps2_dev_tx_if.slave         bus,
  output logic [CHANNELS-1:0] ps2_clk_out,
  output logic [CHANNELS-1:0] ps2_data_out
);
  localparam int DEPTH = 1 << FIFO_BITS;

  typedef enum logic [3:0] {
    ST_IDLE, ST_B0, ST_B1, ST_B2, ST_B3, ST_B4, ST_B5, ST_B6, ST_B7,
    ST_PAR, ST_STOP, ST_END, ST_GAP
  } state_t;

  logic                ps2_s1, ps2_s2, ps2_d, tick;
  logic [CHANNELS-1:0] inhibit;
  logic [FIFO_BITS:0]  wptr [CHANNELS];
  logic [FIFO_BITS:0]  rptr [CHANNELS];
  logic [7:0]          mem  [CHANNELS][DEPTH];
  logic [CHANNELS-1:0] pop;
  state_t              st    [CHANNELS];
  state_t              st_nx [CHANNELS];
  logic [3:0]          cnt    [CHANNELS];
  logic [3:0]          cnt_nx [CHANNELS];
  logic [7:0]          sh    [CHANNELS];
  logic [7:0]          sh_nx [CHANNELS];
  logic [CHANNELS-1:0] par, par_nx, dat_nx;

  // tick is registered so it lands 3 cycles after the raw ps2_clk edge
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ps2_s1 <= 1'b0;
      ps2_s2 <= 1'b0;
      ps2_d  <= 1'b0;
      tick   <= 1'b0;
    end else begin
      ps2_s1 <= ps2_clk;
      ps2_s2 <= ps2_s1;
      ps2_d  <= ps2_s2;
      tick   <= ps2_s2 & ~ps2_d;
    end
  end

`ifdef PS2_HOST_INHIBIT_EN
  logic [CHANNELS-1:0] host_s1, host_s2;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      host_s1 <= '1;
      host_s2 <= '1;
    end else begin
      host_s1 <= host_clk_in;
      host_s2 <= host_s1;
    end
  end
  assign inhibit = ~host_s2;
`else
  logic unused_host;
  assign unused_host = ^host_clk_in;
  assign inhibit     = '0;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
      end
      bus.overflow <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (bus.wr[c] && !bus.full[c]) wptr[c] <= wptr[c] + 1'b1;
        if (pop[c]) rptr[c] <= rptr[c] + 1'b1;
        if (bus.ovf_clr[c]) bus.overflow[c] <= 1'b0;
        else if (bus.wr[c] && bus.full[c]) bus.overflow[c] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.wr[c] && !bus.full[c]) mem[c][wptr[c][FIFO_BITS-1:0]] <= bus.din[8*c +: 8];
    end
  end

  always_comb begin
    bus.full    = '0;
    bus.empty   = '0;
    bus.busy    = '0;
    ps2_clk_out = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      bus.full[c]    = (wptr[c][FIFO_BITS] != rptr[c][FIFO_BITS]) &&
                       (wptr[c][FIFO_BITS-1:0] == rptr[c][FIFO_BITS-1:0]);
      bus.empty[c]   = (wptr[c] == rptr[c]);
      bus.busy[c]    = (st[c] != ST_IDLE);
      ps2_clk_out[c] = ps2_s2 | (st[c] == ST_IDLE) | (st[c] == ST_GAP);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        st[c]  <= ST_IDLE;
        cnt[c] <= '0;
        sh[c]  <= '0;
      end
      par          <= '0;
      ps2_data_out <= '1;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        st[c]  <= st_nx[c];
        cnt[c] <= cnt_nx[c];
        sh[c]  <= sh_nx[c];
      end
      par          <= par_nx;
      ps2_data_out <= dat_nx;
    end
  end

  // The byte is only peeked at start; rptr moves on the stop bit so an aborted frame resends it
  always_comb begin
    par_nx = par;
    dat_nx = ps2_data_out;
    pop    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      st_nx[c]  = st[c];
      cnt_nx[c] = cnt[c];
      sh_nx[c]  = sh[c];
      if (tick) begin
        if (inhibit[c] && (st[c] <= ST_PAR)) begin
          st_nx[c]  = ST_IDLE;
          dat_nx[c] = 1'b1;
        end else begin
          case (st[c])
            ST_IDLE: begin
              if (!bus.empty[c]) begin
                sh_nx[c]  = mem[c][rptr[c][FIFO_BITS-1:0]];
                par_nx[c] = 1'b1;
                dat_nx[c] = 1'b0;
                st_nx[c]  = ST_B0;
              end
            end
            ST_B0, ST_B1, ST_B2, ST_B3, ST_B4, ST_B5, ST_B6, ST_B7: begin
              dat_nx[c] = sh[c][0];
              sh_nx[c]  = {1'b0, sh[c][7:1]};
              par_nx[c] = par[c] ^ sh[c][0];
              st_nx[c]  = state_t'(st[c] + 4'd1);
            end
            ST_PAR: begin
              dat_nx[c] = par[c];
              st_nx[c]  = ST_STOP;
            end
            ST_STOP: begin
              dat_nx[c] = 1'b1;
              pop[c]    = 1'b1;
              st_nx[c]  = ST_END;
            end
            ST_END: begin
              if (GAP == 0) begin
                st_nx[c] = ST_IDLE;
              end else begin
                st_nx[c]  = ST_GAP;
                cnt_nx[c] = 4'(GAP);
              end
            end
            ST_GAP: begin
              if (cnt[c] <= 4'd1) st_nx[c] = ST_IDLE;
              else cnt_nx[c] = cnt[c] - 4'd1;
            end
            default: st_nx[c] = ST_IDLE;
          endcase
        end
      end
    end
  end
endmodule
